rr_mux_4_1: RTL

//   Collecting end of the 1:4 demultiplexer path: merges four input channels onto one output stream.

---
 rtl/mux_pkg.sv | 33 +++
 rtl/rr_arb_4.sv | 24 ++
 rtl/rr_mux_4_1.sv | 76 +++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin 4:1 mux and its matching 1:4 demux.
//   NUM_CH  number of channels
//   SEL_W   width of a channel index
//   pick_t  result of a round-robin search: found flag plus winning index
//   rr_pick round-robin search starting one past the last granted channel
package mux_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Scan from farthest to nearest so the nearest valid channel overwrites the result.
    // Distance NUM_CH wraps back to 'last' itself.
    function automatic pick_t rr_pick(input logic [NUM_CH-1:0] valid,
                                      input logic [SEL_W-1:0]  last);
        pick_t            p;
        logic [SEL_W-1:0] cand;
        p = '0;
        for (int unsigned k = NUM_CH; k >= 1; k--) begin
            cand = last + SEL_W'(k);
            if (valid[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arb_4.sv
// Combinational 4-way round-robin arbiter.
//   req         request vector, one bit per channel
//   last        index of the most recently granted channel
//   gnt_onehot  one-hot grant, all zero when nothing requests
//   gnt_idx     index of the granted channel (holds last search result shape; valid only with any)
//   any         at least one request present
module rr_arb_4
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic [NUM_CH-1:0] gnt_onehot,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              any
);

    pick_t pick;

    assign pick       = rr_pick(req, last);
    assign any        = pick.found;
    assign gnt_idx    = pick.idx;
    assign gnt_onehot = pick.found ? (NUM_CH'(1) << pick.idx) : '0;

endmodule

// File: rtl/rr_mux_4_1.sv
// Round-robin 4:1 merge with one output register stage. Each output word is
// tagged with its source channel index for a downstream 1:4 demux.
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   per-channel word present
//   in_data    channel i word at in_data[i*DATA_W +: DATA_W]
//   in_ready   per-channel accept (combinational, at most one bit set)
//   out_valid  output register holds a word
//   out_data   merged word
//   out_sel    source channel of out_data
//   out_ready  downstream accepts the output word
module rr_mux_4_1
    import mux_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    input  logic                     out_ready
);

    logic [SEL_W-1:0]  last_grant;
    logic [NUM_CH-1:0] gnt_onehot;
    logic [SEL_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic              load_c;
    logic [DATA_W-1:0] sel_word_c;

    rr_arb_4 u_arb (
        .req        (in_valid),
        .last       (last_grant),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    // Output register is free when empty or being drained this cycle.
    assign load_c = ~out_valid | out_ready;

    // Gated by rst_n so no channel sees an accept while reset is held.
    assign in_ready = (rst_n && load_c) ? gnt_onehot : '0;

    // Granted channel's word; other channels' data never reaches the register.
    always_comb begin
        sel_word_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                sel_word_c = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Output stage and round-robin pointer; reset points at ch3 so ch0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= '0;
            last_grant <= SEL_W'(NUM_CH - 1);
        end else if (load_c) begin
            out_valid <= gnt_any;
            if (gnt_any) begin
                out_data   <= sel_word_c;
                out_sel    <= gnt_idx;
                last_grant <= gnt_idx;
            end
        end
    end

endmodule
